cdf_engine: RTL and testbench
=============================

CDF_ENGINE -- requirements
Module: cdf_engine

Interface
REQ-001 Parameter HIST_BASE_ADDR, default 16'h0000, meaning histogram scratch-memory word address of bins 0..7.
REQ-002 Parameter CDF_BASE_ADDR, default 16'h0000, meaning CDF scratch-memory word address of CDF entries 0..7.
REQ-003 Port clock, input, 1, meaning single clock; all state changes on rising edge.
REQ-004 Port reset, input, 1, meaning asynchronous, active-low reset.
REQ-005 Port start_cdf, input, 1, meaning one-cycle start pulse from the master FSM.
REQ-006 Port cdf_hist_raddr, output, 16, meaning histogram scratch-memory read address.
REQ-007 Port cdf_hist_rdata, input, 128, meaning histogram word valid one cycle after its address; bin 8k+i occupies bits [16i+15:16i] of word k.
REQ-008 Port cdf_scratch_mem_WE, output, 1, meaning CDF scratch-memory write enable.
REQ-009 Port cdf_scratch_mem_waddr, output, 16, meaning CDF scratch-memory write address.
REQ-010 Port cdf_scratch_mem_wdata, output, 128, meaning eight 16-bit CDF values, same packing as REQ-007.
REQ-011 Port cdf_min, output, 16, meaning first non-zero CDF value, for the divider stage.
REQ-012 Port cdf_total, output, 16, meaning final CDF value (bin 255).
REQ-013 Port cdf_computation_done, output, 1, meaning one-cycle completion pulse to the master FSM.

Function
REQ-014 The FSM SHALL have states IDLE, READ, ACCUM, WRITE and DONE.
REQ-015 IDLE SHALL move to READ on start_cdf=1 and clear the running sum, word counter k, cdf_min and its found-flag.
REQ-016 READ SHALL drive cdf_hist_raddr = HIST_BASE_ADDR + k and then go to ACCUM.
REQ-017 ACCUM SHALL register eight prefix sums of cdf_hist_rdata on top of the running sum into cdf_scratch_mem_wdata, update the running sum to the eighth value, and go to WRITE.
REQ-018 WRITE SHALL assert cdf_scratch_mem_WE for exactly one cycle with waddr = CDF_BASE_ADDR + k.
REQ-019 WRITE SHALL go to READ with k+1 if k<31, else to DONE.
REQ-020 DONE SHALL assert cdf_computation_done for one cycle, present the final running sum on cdf_total, and return to IDLE.
REQ-021 Latency: start sampled at cycle 0; first WE at cycle 3; 32nd WE at cycle 96; done at cycle 97.
REQ-022 Arithmetic: each addition SHALL saturate at 16'hFFFF, with no wrap-around; a saturated sum stays at 16'hFFFF for the remaining bins.
REQ-023 cdf_min SHALL capture, in bin order, the first CDF value that is non-zero; if all bins are zero, cdf_min=0 and cdf_total=0.
REQ-024 cdf_min and cdf_total SHALL hold their values until the next accepted start_cdf.
REQ-025 start_cdf received outside IDLE SHALL be ignored.
REQ-026 cdf_scratch_mem_WE SHALL be 0 in every state except WRITE.
REQ-027 cdf_hist_raddr SHALL hold its last value outside READ.

Reset
REQ-028 On reset=0, the state SHALL be IDLE at once; k, the running sum, the found-flag, cdf_min, cdf_total, cdf_scratch_mem_wdata, cdf_scratch_mem_waddr and cdf_hist_raddr SHALL clear to 0.
REQ-029 On reset=0, cdf_scratch_mem_WE and cdf_computation_done SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL abort with no further writes.
REQ-031 After reset releases, the block SHALL remain in IDLE until a new start_cdf.

Structure
REQ-032 Shared package hist_eq_pkg SHALL hold NUM_BINS=256, BIN_W=16, BINS_PER_WORD=8, CDF_WORDS=32 and the FSM state encoding.
REQ-033 The combinational eight-lane saturating prefix adder SHALL be the sub-module cdf_prefix8 (inputs: base sum and 128-bit word; outputs: 128-bit prefix word and last sum).

Verification
REQ-034 All bins=1, start at cycle 0 -> word k holds 8k+1..8k+8; WE at cycles 3,6,...,96; done at 97; cdf_min=1; cdf_total=256.
REQ-035 All bins=0 except bin 255=1000 -> words 0..30 all zero; word 31 = {1000, seven zeros in lanes 0..6}; cdf_min=1000; cdf_total=1000.
REQ-036 Bin 0=16'hFFF0, bin 1=16'h0020, rest=1 -> CDF lanes from bin 1 onward =16'hFFFF; cdf_min=16'hFFF0; cdf_total=16'hFFFF.
REQ-037 reset=0 at cycle 40, released at cycle 45 -> WE and done stay 0 from cycle 40; all outputs 0; no activity until the next start_cdf.
REQ-038 Second start_cdf pulse at cycle 20 during a run -> run unaffected; exactly 32 writes; single done pulse at cycle 97.

Source files
------------

// File: rtl/hist_eq_pkg.sv
// Shared constants, FSM encoding and saturating add for the histogram-equalisation CDF stage.
package hist_eq_pkg;
  localparam int unsigned NUM_BINS      = 256;
  localparam int unsigned BIN_W         = 16;
  localparam int unsigned BINS_PER_WORD = 8;
  localparam int unsigned CDF_WORDS     = NUM_BINS / BINS_PER_WORD;
  localparam int unsigned WORD_W        = BIN_W * BINS_PER_WORD;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_ACCUM,
    S_WRITE,
    S_DONE
  } cdf_state_t;

  // Clamps at all-ones instead of wrapping; a clamped sum stays clamped.
  function automatic logic [BIN_W-1:0] sat_add(input logic [BIN_W-1:0] a,
                                               input logic [BIN_W-1:0] b);
    logic [BIN_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[BIN_W] ? '1 : s[BIN_W-1:0];
  endfunction
endpackage

// File: rtl/cdf_engine_if.sv
// Signal bundle between the CDF engine, its scratch memories and the master FSM.
interface cdf_engine_if;
  import hist_eq_pkg::*;

  logic              start_cdf;
  logic [15:0]       hist_raddr;
  logic [WORD_W-1:0] hist_rdata;
  logic              we;
  logic [15:0]       waddr;
  logic [WORD_W-1:0] wdata;
  logic [BIN_W-1:0]  cdf_min;
  logic [BIN_W-1:0]  cdf_total;
  logic              done;

  modport master (
    output start_cdf, hist_rdata,
    input  hist_raddr, we, waddr, wdata, cdf_min, cdf_total, done
  );

  modport slave (
    input  start_cdf, hist_rdata,
    output hist_raddr, we, waddr, wdata, cdf_min, cdf_total, done
  );
endinterface

// File: rtl/cdf_prefix8.sv
// Eight-lane saturating prefix adder: running sum of one histogram word on top of a base sum.
module cdf_prefix8
  import hist_eq_pkg::*;
(
  input  logic [BIN_W-1:0]  i_base,
  input  logic [WORD_W-1:0] i_word,
  output logic [WORD_W-1:0] o_prefix,
  output logic [BIN_W-1:0]  o_last
);

  always_comb begin
    logic [BIN_W-1:0] acc;
    acc      = i_base;
    o_prefix = '0;
    for (int unsigned i = 0; i < BINS_PER_WORD; i++) begin
      acc = sat_add(acc, i_word[i*BIN_W +: BIN_W]);
      o_prefix[i*BIN_W +: BIN_W] = acc;
    end
    o_last = acc;
  end

endmodule

// File: rtl/cdf_engine.sv
// Streams 32 histogram words, writes their saturating running sums as CDF words,
// and reports the first non-zero CDF value and the final total.
module cdf_engine
  import hist_eq_pkg::*;
#(
  parameter logic [15:0] HIST_BASE_ADDR = 16'h0000,
  parameter logic [15:0] CDF_BASE_ADDR  = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_cdf,
  output logic [15:0]       cdf_hist_raddr,
  input  logic [WORD_W-1:0] cdf_hist_rdata,
  output logic              cdf_scratch_mem_WE,
  output logic [15:0]       cdf_scratch_mem_waddr,
  output logic [WORD_W-1:0] cdf_scratch_mem_wdata,
  output logic [BIN_W-1:0]  cdf_min,
  output logic [BIN_W-1:0]  cdf_total,
  output logic              cdf_computation_done
);

  localparam int unsigned K_W = $clog2(CDF_WORDS);
  localparam logic [K_W-1:0] K_LAST = K_W'(CDF_WORDS - 1);

  cdf_state_t        r_state;
  logic [K_W-1:0]    r_k;
  logic [BIN_W-1:0]  r_sum;
  logic              r_found;
  logic [BIN_W-1:0]  r_min;
  logic [BIN_W-1:0]  r_total;
  logic [WORD_W-1:0] r_wdata;
  logic [15:0]       r_waddr;
  logic [15:0]       r_raddr;
  logic              r_we;
  logic              r_done;

  logic [WORD_W-1:0] w_prefix;
  logic [BIN_W-1:0]  w_last;
  logic              w_nz;
  logic [BIN_W-1:0]  w_nz_val;
  logic [K_W-1:0]    w_k_next;

  cdf_prefix8 u_prefix (
    .i_base   (r_sum),
    .i_word   (cdf_hist_rdata),
    .o_prefix (w_prefix),
    .o_last   (w_last)
  );

  // Descending scan so the lowest-numbered non-zero lane wins.
  always_comb begin
    w_nz     = 1'b0;
    w_nz_val = '0;
    for (int unsigned i = BINS_PER_WORD; i > 0; i--) begin
      if (w_prefix[(i-1)*BIN_W +: BIN_W] != '0) begin
        w_nz     = 1'b1;
        w_nz_val = w_prefix[(i-1)*BIN_W +: BIN_W];
      end
    end
  end

  assign w_k_next = r_k + K_W'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_sum   <= '0;
      r_found <= 1'b0;
      r_min   <= '0;
      r_total <= '0;
      r_wdata <= '0;
      r_waddr <= '0;
      r_raddr <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_cdf) begin
            r_sum   <= '0;
            r_k     <= '0;
            r_min   <= '0;
            r_found <= 1'b0;
            r_raddr <= HIST_BASE_ADDR;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_state <= S_ACCUM;
        end
        S_ACCUM: begin
          r_wdata <= w_prefix;
          r_sum   <= w_last;
          if (!r_found && w_nz) begin
            r_found <= 1'b1;
            r_min   <= w_nz_val;
          end
          r_we    <= 1'b1;
          r_waddr <= CDF_BASE_ADDR + 16'(r_k);
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (r_k != K_LAST) begin
            r_k     <= w_k_next;
            r_raddr <= HIST_BASE_ADDR + 16'(w_k_next);
            r_state <= S_READ;
          end else begin
            r_total <= r_sum;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cdf_hist_raddr        = r_raddr;
  assign cdf_scratch_mem_WE    = r_we;
  assign cdf_scratch_mem_waddr = r_waddr;
  assign cdf_scratch_mem_wdata = r_wdata;
  assign cdf_min               = r_min;
  assign cdf_total             = r_total;
  assign cdf_computation_done  = r_done;

endmodule

// File: tb/tb_cdf_engine.sv
// Self-checking bench for cdf_engine: table-driven and randomized histograms against a CDF reference model.
module tb_cdf_engine;
  import hist_eq_pkg::*;

  localparam logic [15:0] HB = 16'h0100;
  localparam logic [15:0] CB = 16'h0200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdf_engine_if bus ();

  cdf_engine #(.HIST_BASE_ADDR(HB), .CDF_BASE_ADDR(CB)) dut (
    .clock                 (clk),
    .reset                 (rst_n),
    .start_cdf             (bus.start_cdf),
    .cdf_hist_raddr        (bus.hist_raddr),
    .cdf_hist_rdata        (bus.hist_rdata),
    .cdf_scratch_mem_WE    (bus.we),
    .cdf_scratch_mem_waddr (bus.waddr),
    .cdf_scratch_mem_wdata (bus.wdata),
    .cdf_min               (bus.cdf_min),
    .cdf_total             (bus.cdf_total),
    .cdf_computation_done  (bus.done)
  );

  typedef struct {
    int         kind;
    bit         use_const;
    logic [15:0] min_c;
    logic [15:0] tot_c;
  } vec_t;

  int unsigned hist    [NUM_BINS];
  int unsigned exp_cdf [NUM_BINS];
  int unsigned exp_min, exp_total;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int t_start = 0;

  int           wr_cyc  [$];
  logic [15:0]  wr_addr [$];
  logic [127:0] wr_data [$];
  int           done_cyc[$];

  function automatic logic [127:0] mem_word(input logic [15:0] a);
    logic [127:0] w;
    logic [15:0] off;
    w = '0;
    off = a - HB;
    if (off < 16'd32)
      for (int i = 0; i < 8; i++) w[i*16 +: 16] = 16'(hist[int'(off)*8 + i]);
    return w;
  endfunction

  always @(posedge clk) bus.hist_rdata <= mem_word(bus.hist_raddr);

  always @(posedge clk) begin
    edge_cnt++;
    #1;
    if (bus.we === 1'b1) begin
      wr_cyc.push_back(edge_cnt - t_start);
      wr_addr.push_back(bus.waddr);
      wr_data.push_back(bus.wdata);
    end
    if (bus.done === 1'b1) done_cyc.push_back(edge_cnt - t_start);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: cumulative histogram with clamping at 65535, first non-zero value, final value.
  task automatic build_ref();
    int unsigned s;
    bit found;
    s = 0; found = 0; exp_min = 0;
    for (int b = 0; b < int'(NUM_BINS); b++) begin
      s = s + hist[b];
      if (s > 65535) s = 65535;
      exp_cdf[b] = s;
      if (!found && s != 0) begin
        found = 1; exp_min = s;
      end
    end
    exp_total = s;
  endtask

  function automatic logic [127:0] exp_word(input int k);
    logic [127:0] w;
    for (int i = 0; i < 8; i++) w[i*16 +: 16] = 16'(exp_cdf[8*k + i]);
    return w;
  endfunction

  task automatic fill(input int kind);
    int nz;
    nz = int'($urandom_range(1, 200));
    for (int b = 0; b < int'(NUM_BINS); b++) begin
      case (kind)
        0: hist[b] = 1;
        1: hist[b] = (b == 255) ? 1000 : 0;
        2: hist[b] = (b == 0) ? 32'hFFF0 : (b == 1) ? 32'h20 : 1;
        3: hist[b] = 0;
        4: hist[b] = $urandom_range(0, 300);
        5: hist[b] = (b < nz) ? 0 : $urandom_range(0, 50);
        default: hist[b] = $urandom_range(0, 2000);
      endcase
    end
  endtask

  task automatic run_cdf(input int extra_at);
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); done_cyc.delete();
    @(negedge clk);
    bus.start_cdf = 1'b1;
    t_start = edge_cnt;
    @(negedge clk);
    bus.start_cdf = 1'b0;
    for (int n = 0; n < 300 && done_cyc.size() == 0; n++) begin
      @(negedge clk);
      if (extra_at > 0 && edge_cnt - t_start == extra_at) begin
        bus.start_cdf = 1'b1;
        @(negedge clk);
        bus.start_cdf = 1'b0;
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic verify(input string tag, input bit use_const,
                        input logic [15:0] min_c, input logic [15:0] tot_c);
    int nw;
    chk({tag, " done_count"}, 128'(done_cyc.size()), 128'd1);
    if (done_cyc.size() > 0) chk({tag, " done_cycle"}, 128'(done_cyc[0]), 128'd97);
    chk({tag, " write_count"}, 128'(wr_cyc.size()), 128'd32);
    nw = (wr_cyc.size() < 32) ? wr_cyc.size() : 32;
    for (int k = 0; k < nw; k++) begin
      chk($sformatf("%s wr%0d_cycle", tag, k), 128'(wr_cyc[k]), 128'(3 + 3*k));
      chk($sformatf("%s wr%0d_addr", tag, k), 128'(wr_addr[k]), 128'(CB + 16'(k)));
      chk($sformatf("%s wr%0d_data", tag, k), wr_data[k], exp_word(k));
    end
    if (use_const) begin
      chk({tag, " cdf_min"}, 128'(bus.cdf_min), 128'(min_c));
      chk({tag, " cdf_total"}, 128'(bus.cdf_total), 128'(tot_c));
    end else begin
      chk({tag, " cdf_min"}, 128'(bus.cdf_min), 128'(exp_min));
      chk({tag, " cdf_total"}, 128'(bus.cdf_total), 128'(exp_total));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " we"}, 128'(bus.we), 128'd0);
    chk({tag, " done"}, 128'(bus.done), 128'd0);
    chk({tag, " raddr"}, 128'(bus.hist_raddr), 128'd0);
    chk({tag, " waddr"}, 128'(bus.waddr), 128'd0);
    chk({tag, " wdata"}, bus.wdata, 128'd0);
    chk({tag, " cdf_min"}, 128'(bus.cdf_min), 128'd0);
    chk({tag, " cdf_total"}, 128'(bus.cdf_total), 128'd0);
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{kind: 0, use_const: 1'b1, min_c: 16'd1,     tot_c: 16'd256};
    vecs[1] = '{kind: 1, use_const: 1'b1, min_c: 16'd1000,  tot_c: 16'd1000};
    vecs[2] = '{kind: 2, use_const: 1'b1, min_c: 16'hFFF0,  tot_c: 16'hFFFF};
    vecs[3] = '{kind: 3, use_const: 1'b1, min_c: 16'd0,     tot_c: 16'd0};
    vecs[4] = '{kind: 4, use_const: 1'b0, min_c: 16'd0,     tot_c: 16'd0};
    vecs[5] = '{kind: 5, use_const: 1'b0, min_c: 16'd0,     tot_c: 16'd0};
    vecs[6] = '{kind: 6, use_const: 1'b0, min_c: 16'd0,     tot_c: 16'd0};

    bus.start_cdf = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle no_write", 128'(wr_cyc.size()), 128'd0);
    chk("idle no_done", 128'(done_cyc.size()), 128'd0);

    for (int v = 0; v < 7; v++) begin
      fill(vecs[v].kind);
      build_ref();
      run_cdf(0);
      verify($sformatf("vec%0d", v), vecs[v].use_const, vecs[v].min_c, vecs[v].tot_c);
      if (vecs[v].kind == 1 && wr_data.size() >= 32)
        chk("vec1 word31_lane7_only", wr_data[31], {16'd1000, 112'd0});
    end

    for (int r = 0; r < 6; r++) begin
      fill(4 + (r % 3));
      build_ref();
      run_cdf(0);
      verify($sformatf("rand%0d", r), 1'b0, 16'd0, 16'd0);
    end

    fill(4);
    build_ref();
    run_cdf(20);
    verify("restart_ignored", 1'b0, 16'd0, 16'd0);

    // Abort mid-run with reset, then confirm the block stays quiet until restarted.
    fill(0);
    build_ref();
    @(negedge clk);
    bus.start_cdf = 1'b1;
    t_start = edge_cnt;
    @(negedge clk);
    bus.start_cdf = 1'b0;
    for (int n = 0; n < 100 && edge_cnt - t_start < 40; n++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); done_cyc.delete();
    chk_all_zero("midreset");
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("postreset no_write", 128'(wr_cyc.size()), 128'd0);
    chk("postreset no_done", 128'(done_cyc.size()), 128'd0);
    chk_all_zero("postreset");

    run_cdf(0);
    verify("recovery", 1'b1, 16'd1, 16'd256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
